// File: rtl/rotate_rom_arbiter.sv
// Two-requester arbiter for the shared rotation sin/cos ROM with tag pipeline.
// Define ROTATE_ROM_ARB_PRIO_EN for fixed priority (req0 wins); default is round-robin.
module rotate_rom_arbiter #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0,
  input  logic                  req1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  rvalid0,
  output logic                  rvalid1,
  output logic [DATA_WIDTH-1:0] rdata0,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  output logic                  rom_en,
  input  logic [DATA_WIDTH-1:0] rom_rd_data,
  output logic                  busy
);

  if (RD_LATENCY < 1 || RD_LATENCY > 2) begin : g_bad_lat
    $error("rotate_rom_arbiter: RD_LATENCY must be 1 or 2");
  end

  logic                  sel0;
  logic                  a_vld;
  logic                  a_tag;
  logic [RD_LATENCY-1:0] p_vld;
  logic [RD_LATENCY-1:0] p_tag;

`ifdef ROTATE_ROM_ARB_PRIO_EN
  always_comb begin
    sel0 = req0;
  end
`else
  logic last;

  // last=1 out of reset so requester 0 wins the first contention
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last <= 1'b1;
    end else if (gnt0) begin
      last <= 1'b0;
    end else if (gnt1) begin
      last <= 1'b1;
    end
  end

  always_comb begin
    sel0 = req0 & (~req1 | last);
  end
`endif

  assign gnt0 = ~rst & sel0;
  assign gnt1 = ~rst & req1 & ~sel0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_vld    <= 1'b0;
      a_tag    <= 1'b0;
      rom_addr <= '0;
    end else begin
      a_vld <= gnt0 | gnt1;
      a_tag <= gnt1;
      if (gnt0) begin
        rom_addr <= addr0;
      end else if (gnt1) begin
        rom_addr <= addr1;
      end
    end
  end

  // Bit 0 is youngest; the top bit lines up with ROM data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_vld <= '0;
      p_tag <= '0;
    end else begin
      p_vld <= RD_LATENCY'({p_vld, a_vld});
      p_tag <= RD_LATENCY'({p_tag, a_tag});
    end
  end

  assign rvalid0 = p_vld[RD_LATENCY-1] & ~p_tag[RD_LATENCY-1];
  assign rvalid1 = p_vld[RD_LATENCY-1] & p_tag[RD_LATENCY-1];
  assign rdata0  = rom_rd_data;
  assign rdata1  = rom_rd_data;
  assign rom_en  = a_vld | (|p_vld);
  assign busy    = rom_en | (~rst & (req0 | req1));

endmodule

// File: tb/tb_rotate_rom_arbiter.sv
// Bench for rotate_rom_arbiter: lat-1 and lat-2 instances share stimulus,
// each with its own ROM model and scoreboard queue.
module tb_rotate_rom_arbiter;

  typedef struct {
    logic        tag;
    logic [31:0] data;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1;
  logic [9:0]  addr0, addr1;

  logic        g0_a, g1_a, rv0_a, rv1_a, en_a, busy_a;
  logic [31:0] rd0_a, rd1_a, rom_a;
  logic [9:0]  ra_a;
  logic        g0_b, g1_b, rv0_b, rv1_b, en_b, busy_b;
  logic [31:0] rd0_b, rd1_b, rom_b, stg_b;
  logic [9:0]  ra_b;

  int checks = 0;
  int failures = 0;
  int cyc_n = 0;
  exp_t qa[$];
  exp_t qb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  function automatic logic [31:0] rom_word(input logic [9:0] a);
    return {6'h2b, a, 6'h15, a};
  endfunction

  rotate_rom_arbiter #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .RD_LATENCY(1)) u_a (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1),
    .addr0(addr0), .addr1(addr1), .gnt0(g0_a), .gnt1(g1_a),
    .rvalid0(rv0_a), .rvalid1(rv1_a), .rdata0(rd0_a), .rdata1(rd1_a),
    .rom_addr(ra_a), .rom_en(en_a), .rom_rd_data(rom_a), .busy(busy_a)
  );

  rotate_rom_arbiter #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .RD_LATENCY(2)) u_b (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1),
    .addr0(addr0), .addr1(addr1), .gnt0(g0_b), .gnt1(g1_b),
    .rvalid0(rv0_b), .rvalid1(rv1_b), .rdata0(rd0_b), .rdata1(rd1_b),
    .rom_addr(ra_b), .rom_en(en_b), .rom_rd_data(rom_b), .busy(busy_b)
  );

  // ROM models: registered read, optional output register gated by rd_oce
  always @(posedge clk) if (en_a) rom_a <= rom_word(ra_a);
  always @(posedge clk) begin
    if (en_b) begin
      stg_b <= rom_word(ra_b);
      rom_b <= stg_b;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h cycle=%0d", nm, act, exp, cyc_n);
    end
  endtask

  task automatic cmp_ret(input string nm, input logic v0, input logic v1,
                         input logic [31:0] d0, input logic [31:0] d1, input exp_t e);
    logic [31:0] d;
    checks++;
    d = v1 ? d1 : d0;
    if ((v0 && v1) || (v1 != e.tag) || (d !== e.data) || (cyc_n != e.due)) begin
      failures++;
      $display("FAIL %s got rv=%b%b data=%0h cyc=%0d exp tag=%0d data=%0h cyc=%0d",
               nm, v1, v0, d, cyc_n, e.tag, e.data, e.due);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (rv0_a || rv1_a) begin
        if (qa.size() == 0) begin
          checks++; failures++;
          $display("FAIL ret_lat1 got unexpected rvalid exp none cycle=%0d", cyc_n);
        end else begin
          e = qa.pop_front();
          cmp_ret("ret_lat1", rv0_a, rv1_a, rd0_a, rd1_a, e);
        end
      end else if (qa.size() != 0 && qa[0].due <= cyc_n) begin
        e = qa.pop_front();
        checks++; failures++;
        $display("FAIL ret_lat1 got no rvalid exp tag=%0d at cycle=%0d", e.tag, e.due);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (rv0_b || rv1_b) begin
        if (qb.size() == 0) begin
          checks++; failures++;
          $display("FAIL ret_lat2 got unexpected rvalid exp none cycle=%0d", cyc_n);
        end else begin
          e = qb.pop_front();
          cmp_ret("ret_lat2", rv0_b, rv1_b, rd0_b, rd1_b, e);
        end
      end else if (qb.size() != 0 && qb[0].due <= cyc_n) begin
        e = qb.pop_front();
        checks++; failures++;
        $display("FAIL ret_lat2 got no rvalid exp tag=%0d at cycle=%0d", e.tag, e.due);
      end
    end
  end

  // One cycle of stimulus; called just after a rising edge
  task automatic step(input logic r0, input logic r1, input logic [9:0] a0,
                      input logic [9:0] a1, input logic e0, input logic e1,
                      input logic push);
    req0 = r0; req1 = r1; addr0 = a0; addr1 = a1;
    @(negedge clk);
    chk("gnt_lat1", {g1_a, g0_a}, {e1, e0});
    chk("gnt_lat2", {g1_b, g0_b}, {e1, e0});
    if (push && e0) begin
      qa.push_back('{1'b0, rom_word(a0), cyc_n + 2});
      qb.push_back('{1'b0, rom_word(a0), cyc_n + 3});
    end
    if (push && e1) begin
      qa.push_back('{1'b1, rom_word(a1), cyc_n + 2});
      qb.push_back('{1'b1, rom_word(a1), cyc_n + 3});
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 10'h0, 10'h0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [9:0] hold_a, hold_b;
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; addr0 = '0; addr1 = '0;
    @(negedge clk);
    chk("reset_lat1", {g0_a, g1_a, rv0_a, rv1_a, en_a, busy_a, ra_a}, 16'h0);
    chk("reset_lat2", {g0_b, g1_b, rv0_b, rv1_b, en_b, busy_b, ra_b}, 16'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(2);

    // Contention: both requesters held high
    for (int i = 0; i < 6; i++) begin
`ifdef ROTATE_ROM_ARB_PRIO_EN
      step(1'b1, 1'b1, 10'h010, 10'h020, 1'b1, 1'b0, 1'b1);
`else
      step(1'b1, 1'b1, 10'h010, 10'h020, (i % 2) == 0, (i % 2) == 1, 1'b1);
`endif
    end
    step(1'b0, 1'b1, 10'h010, 10'h020, 1'b0, 1'b1, 1'b1);
    idle(5);
    chk("drain_contention", qa.size() + qb.size(), 0);

    // Single lookup
    step(1'b1, 1'b0, 10'h040, 10'h0, 1'b1, 1'b0, 1'b1);
    req0 = 1'b0;
    @(negedge clk);
    chk("rom_addr_lat1", ra_a, 10'h040);
    chk("rom_addr_lat2", ra_b, 10'h040);
    chk("rom_en_t1", {en_a, en_b}, 2'b11);
    chk("busy_t1", {busy_a, busy_b}, 2'b11);
    @(posedge clk); #1;
    idle(4);

    // Back-to-back streaming on requester 1
    for (int i = 0; i < 8; i++)
      step(1'b0, 1'b1, 10'h0, 10'(i), 1'b0, 1'b1, 1'b1);
    idle(5);
    chk("drain_stream", qa.size() + qb.size(), 0);

    // Reset mid-flight: three grants, then reset
    step(1'b1, 1'b0, 10'h100, 10'h0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 10'h101, 10'h0, 1'b1, 1'b0, 1'b0);
    req0 = 1'b1; addr0 = 10'h102;
    #1;
    chk("gnt_third", {g0_a, g0_b}, 2'b11);
    rst = 1'b1; req0 = 1'b0;
    @(negedge clk);
    chk("rst_mid_lat1", {rv0_a, rv1_a, en_a, busy_a}, 4'h0);
    chk("rst_mid_lat2", {rv0_b, rv1_b, en_b, busy_b}, 4'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(5);
    step(1'b0, 1'b1, 10'h0, 10'h3ff, 1'b0, 1'b1, 1'b1);
    idle(5);
    chk("drain_post_reset", qa.size() + qb.size(), 0);

    // Idle power
    hold_a = ra_a; hold_b = ra_b;
    for (int i = 0; i < 20; i++) begin
      idle(1);
      chk("idle_en", {en_a, en_b}, 2'b00);
      chk("idle_addr", {ra_a, ra_b}, {hold_a, hold_b});
    end
    chk("idle_busy", {busy_a, busy_b}, 2'b00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rotate_rom_arbiter.md
# rotate_rom_arbiter

Shares the single-port rotation coefficient ROM (`ipml_rom_v1_5_rotate_rom`, sin/cos table) between two lookup requesters in the rotation datapath. These are typically the sine and cosine coordinate units. The block arbitrates one read per cycle, drives the ROM address and clock enable, and tracks each lookup through the ROM's fixed read latency. It then returns the data to the owning requester with a valid pulse. It sits between the rotation address generators and the ROM wrapper.

## Interface
Parameters:
- `ADDR_WIDTH`, 10, ROM address width; equals the ROM `c_ADDR_WIDTH`.
- `DATA_WIDTH`, 32, ROM data width; equals the ROM `c_DATA_WIDTH`.
- `RD_LATENCY`, 1, ROM read cycles from address to data. Legal values: 1 (`c_OUTPUT_REG`=0) or 2 (`c_OUTPUT_REG`=1).

Ports:
- `clk`  in  1  system clock; same clock as the ROM.
- `rst`  in  1  reset; asynchronous assert, active-high.
- `req0`, `req1`  in  1 each  lookup request; held high until granted.
- `addr0`, `addr1`  in  ADDR_WIDTH each  lookup address; stable while the matching req is high.
- `gnt0`, `gnt1`  out  1 each  grant pulse; combinational.
- `rvalid0`, `rvalid1`  out  1 each  returned-data pulse.
- `rdata0`, `rdata1`  out  DATA_WIDTH each  returned data; valid only when the matching rvalid is high.
- `rom_addr`  out  ADDR_WIDTH  to ROM `addr`.
- `rom_en`  out  1  to ROM `clk_en` and `rd_oce`.
- `rom_rd_data`  in  DATA_WIDTH  from ROM `rd_data`.
- `busy`  out  1  high while any lookup is in flight.

## Operation
- **Arbitration.** `gnt_k` = `req_k` AND selected. At most one grant per cycle.
  - Round-robin pointer `last`: when both requests are high, grant the requester that is not `last`. Reset value is `last`=1, so requester 0 wins first.
  - `last` updates on every grant.
  - A single requester is granted immediately, every cycle, with no bubbles.
- **Address stage.** On the clock edge after a grant:
  - `rom_addr` <= granted addr.
  - `a_vld` <= 1, `a_tag` <= granted index.
  - If there is no grant, `a_vld` <= 0 and `rom_addr` holds its value.
- **Tag pipeline.** Shift register of depth `RD_LATENCY`, carrying {vld, tag}, fed from {`a_vld`, `a_tag`}. The output stage asserts `rvalid_tag` for one cycle.
- **Data return.** `rdata0` = `rdata1` = `rom_rd_data` (shared bus); validity is qualified by `rvalid_k`.
- **ROM enable.** `rom_en` = `a_vld` OR any vld in the tag pipeline. `busy` = `rom_en` OR any req.
- **No backpressure.** Requesters must accept return data on the rvalid cycle. Unlimited outstanding lookups.
- **Reset.**
  - Outputs: all gnt/rvalid = 0, `rom_addr` = 0, `rom_en` = 0, `busy` = 0, pipeline cleared.
  - Reset mid-operation discards every in-flight lookup; no rvalid is issued for any of them.
- **Illegal parameter.** `RD_LATENCY` outside 1..2 triggers a simulation `$error` at elaboration.

## Timing
- Request high in cycle T → `gnt` in T → `rom_addr` valid in T+1 → `rvalid` in T+1+`RD_LATENCY`.
  - `RD_LATENCY`=1: request-to-data latency is 2 cycles.
  - `RD_LATENCY`=2: request-to-data latency is 3 cycles.
- Throughput: one lookup per cycle total. Data returns in grant order.
- Both requesters continuously high: grants alternate 0,1,0,1…
- A request dropped before its grant is legal; no lookup is issued.
- A request that stays high after its grant is treated as a new request in the next cycle.

## Configuration
- Macro `ROTATE_ROM_ARB_PRIO_EN`.
  - **Defined:** fixed priority. Requester 0 always wins; requester 1 is granted only when `req0` is low. The `last` pointer is removed.
  - **Undefined (default):** round-robin as described above.
- Latency, reset behaviour and return ordering are identical in both modes.

## Test plan
- **Single lookup, `RD_LATENCY`=1.** `req0` with `addr0`=0x040 for one cycle at T.
  - Expect `gnt0` at T, `rom_addr`=0x040 at T+1, `rvalid0` at T+2 with `rdata0` = ROM[0x040].
  - `rvalid1` stays 0 throughout.
- **Contention.** `req0` and `req1` held high for 6 cycles, `addr0`=0x010, `addr1`=0x020.
  - Round-robin: grants 0,1,0,1,0,1, then rvalid0/rvalid1 alternate with the correct words.
  - With `ROTATE_ROM_ARB_PRIO_EN`: six `gnt0`, no `gnt1` until `req0` drops.
- **Back-to-back streaming, `RD_LATENCY`=2.** `req1` high for 8 cycles, `addr1` stepping 0..7.
  - Expect 8 consecutive `rvalid1` pulses starting at T+3, data ROM[0..7] in order.
- **Reset mid-flight.** Grant 3 lookups, then assert `rst` at T+2.
  - Expect no further rvalid, `rom_en`=0 and `busy`=0 immediately.
  - After release, a new lookup returns normally.
- **Idle power.** No requests for 20 cycles.
  - Expect `rom_en`=0 and `rom_addr` unchanged.
  - `rom_en` is 1 only during the `a_vld` and tag-pipeline cycles of an issued lookup.
